pio_edge_logger: RTL and testbench
==================================

# pio_edge_logger

Timestamped transition logger placed directly downstream of the single-bit PIO output. It samples the PIO `out_port` level, detects rising and falling edges, and pushes each edge with a free-running timestamp into a small FIFO. The HPS drains the FIFO over an Avalon-MM slave and can take an interrupt while entries are pending. The block closes the loop on software-driven toggles so their timing can be measured and logged.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..256.
- `TS_WIDTH`, 31: timestamp counter width; fixed at 31 so entry = {polarity, ts} fills 32 bits.

Ports:
- `clk` input 1: single clock; all logic in this domain.
- `reset` input 1: reset, asynchronous, active-high.
- `address` input 2: Avalon-MM word address.
- `chipselect` input 1: slave select.
- `read_n` input 1: active-low read strobe.
- `write_n` input 1: active-low write strobe.
- `writedata` input 32: write data.
- `readdata` output 32: read data, combinational from `address` and state, zero wait states.
- `level_in` input 1: monitored level, connected to PIO `out_port`; asynchronous to `clk`.
- `irq` output 1: level interrupt.

## Operation

- Reset clears all state: sync flops, prev level, counter, FIFO pointers/count, overflow, enable, irq_en. Outputs after reset: `readdata`=0 for DATA address (FIFO empty), `irq`=0.
- Input path: 2-flop synchronizer `s1`→`s2`, then `prev`<=`s2` every cycle, regardless of enable. Edge event when `s2 != prev`; polarity = `s2` (1 rising, 0 falling).
- Timestamp: TS_WIDTH-bit counter. +1 per clock while enable=1, holds while 0. Wraps from 2^31-1 to 0 silently.
- Push: on an edge event with enable=1, write {`s2`, counter} at tail. Counter value is the pre-increment value of the push cycle.
- Full: an edge arriving while full and not popped that cycle is dropped and sets sticky `overflow`. A push and pop in the same cycle while full are both accepted; count unchanged, no overflow.
- Registers:
  - 0 DATA (RO): head entry. A read (`chipselect & ~read_n`) pops one entry. Empty: returns 0, no pop, no error.
  - 1 STATUS: [8:0] count (0..DEPTH), [9] empty, [10] full, [11] overflow. Write with writedata[11]=1 clears overflow (W1C); other bits ignored.
  - 2 CONTROL (RW): [0] enable, [1] irq_en. Write with [2]=1 performs clear: flush FIFO (count 0), counter 0, overflow 0. Bit [2] self-clears and reads 0. Enable/irq_en take the written values in the same write.
  - 3 TIMESTAMP (RO): live counter, zero-extended.
- `irq` = irq_en & ~empty, from registered state.
- Clear has priority over push and pop in the same cycle; a coincident edge is discarded and not flagged as overflow.
- Writes to DATA and TIMESTAMP are ignored. Reads of non-DATA addresses have no side effects.

## Timing

- `level_in` changes before edge N. `s1` captures at N, `s2` at N+1. The event is pushed at edge N+2, so count/empty/irq update after N+2. Latency is 2 clocks to detection and 3 to visibility.
- Pop takes effect at the clock edge ending the read cycle. The next read sees the following entry.
- Each edge event occupies one cycle, so back-to-back toggles on consecutive cycles log as consecutive entries with timestamps differing by 1.
- A CONTROL write setting enable=1 at edge E increments the counter from E+1. Edges detected at E+1 onward are logged.
- `reset` assertion mid-operation clears everything immediately, asynchronously. Deassertion is released on a clk edge; the first event can be pushed no earlier than the 3rd edge after release.

## Test plan

- Reset, enable=1, toggle `level_in` 0→1 at t0 then 1→0 10 clocks later. Required: count=2; DATA reads give 0x8000_0000|T and T+10 with bit31=0; then empty=1 and `irq` low.
- 17 edges with DEPTH=16 and no reads. Required: count=16, full=1, overflow=1; 16 entries in order; 17th absent. STATUS write 0x800 clears overflow.
- FIFO full, DATA read coincident with a new edge detection. Required: count stays 16, overflow stays 0, new entry appears last.
- irq_en=1, single edge. Required: `irq` rises 3 clocks after the input change; reading DATA drops `irq` the next cycle. Read DATA when empty returns 0 and count stays 0.
- Preload counter near wrap via a long run, or a TS_WIDTH-reduced variant if supported by the bench. Required: TIMESTAMP wraps 0x7FFF_FFFF→0, and an entry logged after the wrap holds the small value.
- Write CONTROL 0x5 (clear + enable) with 5 entries queued and an edge in flight. Required: count=0, TIMESTAMP=0 next cycle, the in-flight edge is dropped, and overflow=0. Async `reset` pulse mid-stream also returns all registers to 0.

Source files
------------

// File: rtl/pio_edge_logger_if.sv
// Avalon-MM slave bundle for the PIO edge logger: word address, strobes, data.
// The host side uses the master modport; the logger uses the slave modport.
interface pio_edge_logger_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_edge_logger.sv
// Timestamped edge logger for a single PIO output bit. Each detected edge is
// queued as {polarity, timestamp} and drained by the host over Avalon-MM.
module pio_edge_logger #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 31
) (
  input  logic               clk,
  input  logic               reset,
  pio_edge_logger_if.slave   bus,
  input  logic               level_in,
  output logic               irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;
  localparam logic [1:0] ADDR_TS      = 2'd3;

  logic                s1_reg, s2_reg, prev_reg;
  logic [TS_WIDTH-1:0] ts_reg, ts_next;
  logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]       count_reg, count_next;
  logic                overflow_reg, overflow_next;
  logic                enable_reg, enable_next;
  logic                irq_en_reg, irq_en_next;

  logic [31:0]         mem [DEPTH];

  logic                rd_strobe, wr_strobe;
  logic                empty, full;
  logic                edge_evt, clear, pop, push_req, push, drop, ovf_w1c;
  logic [30:0]         ts_ext;
  logic [31:0]         entry;
  logic [8:0]          count_field;
  logic                unused_wdata;

  assign rd_strobe = bus.chipselect & ~bus.read_n;
  assign wr_strobe = bus.chipselect & ~bus.write_n;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));

  // Clear outranks everything else, so a coincident edge or pop is simply lost.
  assign edge_evt = s2_reg ^ prev_reg;
  assign clear    = wr_strobe & (bus.address == ADDR_CONTROL) & bus.writedata[2];
  assign ovf_w1c  = wr_strobe & (bus.address == ADDR_STATUS) & bus.writedata[11];
  assign pop      = rd_strobe & (bus.address == ADDR_DATA) & ~empty & ~clear;
  assign push_req = edge_evt & enable_reg & ~clear;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign ts_ext = 31'(ts_reg);
  assign entry  = {s2_reg, ts_ext};

  assign unused_wdata = ^{bus.writedata[31:12], bus.writedata[10:3]};

  always_comb begin
    ts_next       = ts_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    enable_next   = enable_reg;
    irq_en_next   = irq_en_reg;

    if (wr_strobe && bus.address == ADDR_CONTROL) begin
      enable_next = bus.writedata[0];
      irq_en_next = bus.writedata[1];
    end

    if (clear) begin
      ts_next       = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      if (enable_reg)
        ts_next = ts_reg + TS_WIDTH'(1);
      if (push)
        wr_ptr_next = wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_next = rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
      // A drop in the same cycle as the W1C keeps the flag set.
      if (ovf_w1c)
        overflow_next = 1'b0;
      if (drop)
        overflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      prev_reg     <= 1'b0;
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      enable_reg   <= 1'b0;
      irq_en_reg   <= 1'b0;
    end else begin
      s1_reg       <= level_in;
      s2_reg       <= s1_reg;
      prev_reg     <= s2_reg;
      ts_reg       <= ts_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      enable_reg   <= enable_next;
      irq_en_reg   <= irq_en_next;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= entry;
  end

  assign count_field = 9'(count_reg);

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata = empty ? 32'd0 : mem[rd_ptr_reg];
      ADDR_STATUS:  bus.readdata = 32'({overflow_reg, full, empty, count_field});
      ADDR_CONTROL: bus.readdata = {30'd0, irq_en_reg, enable_reg};
      ADDR_TS:      bus.readdata = 32'(ts_reg);
      default:      bus.readdata = '0;
    endcase
  end

  assign irq = irq_en_reg & ~empty;

endmodule

// File: tb/tb_pio_edge_logger.sv
// Directed bench for pio_edge_logger: a full-width instance plus a 4-bit
// timestamp instance used to exercise counter wrap in a short run.
module tb_pio_edge_logger;

  logic clk = 1'b0;
  logic reset;
  logic level1, level2;
  logic irq1, irq2;
  int   tests_run    = 0;
  int   tests_failed = 0;

  pio_edge_logger_if bus1 ();
  pio_edge_logger_if bus2 ();

  pio_edge_logger #(.DEPTH(16), .TS_WIDTH(31)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .level_in(level1), .irq(irq1)
  );

  pio_edge_logger #(.DEPTH(16), .TS_WIDTH(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .level_in(level2), .irq(irq2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic [1:0] a, input logic cs,
                       input logic rn, input logic wn, input logic [31:0] wd);
    if (which == 1) begin
      bus1.address = a; bus1.chipselect = cs; bus1.read_n = rn;
      bus1.write_n = wn; bus1.writedata = wd;
    end else begin
      bus2.address = a; bus2.chipselect = cs; bus2.read_n = rn;
      bus2.write_n = wn; bus2.writedata = wd;
    end
  endtask

  function automatic logic [31:0] rdata(input int which);
    return (which == 1) ? bus1.readdata : bus2.readdata;
  endfunction

  // Strobed read: sample mid-cycle, side effect lands on the next edge.
  task automatic bus_read(input int which, input logic [1:0] a, output logic [31:0] d);
    drive(which, a, 1'b1, 1'b0, 1'b1, 32'd0);
    #2;
    d = rdata(which);
    @(posedge clk);
    #1;
    drive(which, a, 1'b0, 1'b1, 1'b1, 32'd0);
  endtask

  task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] wd);
    drive(which, a, 1'b1, 1'b1, 1'b0, wd);
    @(posedge clk);
    #1;
    drive(which, a, 1'b0, 1'b1, 1'b1, 32'd0);
  endtask

  // Unstrobed look at readdata; never pops.
  task automatic peek(input int which, input logic [1:0] a, output logic [31:0] d);
    drive(which, a, 1'b0, 1'b1, 1'b1, 32'd0);
    #1;
    d = rdata(which);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp;

    reset  = 1'b1;
    level1 = 1'b0;
    level2 = 1'b0;
    drive(1, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
    drive(2, 2'd0, 1'b0, 1'b1, 1'b1, 32'd0);
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    peek(1, 2'd0, d);  check("reset_data", d, 32'h0);
    peek(1, 2'd1, d);  check("reset_status", d, 32'h200);
    peek(1, 2'd2, d);  check("reset_control", d, 32'h0);
    peek(1, 2'd3, d);  check("reset_ts", d, 32'h0);
    check("reset_irq", 32'(irq1), 32'h0);

    // Timestamp wrap on the 4-bit instance
    bus_write(2, 2'd2, 32'h1);
    tick(14);
    peek(2, 2'd3, d);  check("wrap_ts_e", d, 32'hE);
    tick(1);
    peek(2, 2'd3, d);  check("wrap_ts_f", d, 32'hF);
    tick(1);
    peek(2, 2'd3, d);  check("wrap_ts_0", d, 32'h0);
    level2 = 1'b1;
    tick(3);
    bus_read(2, 2'd0, d);  check("wrap_entry", d, 32'h8000_0002);
    check("wrap_irq_off", 32'(irq2), 32'h0);

    // Rising then falling edge ten clocks apart
    bus_write(1, 2'd2, 32'h1);
    level1 = 1'b1;
    tick(10);
    level1 = 1'b0;
    tick(3);
    bus_read(1, 2'd1, d);  check("two_status", d, 32'h002);
    bus_read(1, 2'd0, d);  check("two_rise", d, 32'h8000_0002);
    bus_read(1, 2'd0, d);  check("two_fall", d, 32'h0000_000C);
    bus_read(1, 2'd1, d);  check("two_empty", d, 32'h200);
    check("two_irq", 32'(irq1), 32'h0);

    // Seventeen back-to-back edges into a 16-deep FIFO
    bus_write(1, 2'd2, 32'h5);
    for (int i = 0; i < 17; i++) begin
      level1 = ~level1;
      tick(1);
    end
    tick(3);
    bus_read(1, 2'd1, d);  check("ovf_status", d, 32'hC10);
    bus_write(1, 2'd1, 32'h800);
    bus_read(1, 2'd1, d);  check("ovf_w1c", d, 32'h410);

    // Pop coincident with a push while full
    level1 = ~level1;
    tick(2);
    bus_read(1, 2'd0, d);  check("full_pop_head", d, 32'h8000_0002);
    bus_read(1, 2'd1, d);  check("full_pop_status", d, 32'h410);
    for (int i = 1; i < 16; i++) begin
      exp = ((i % 2 == 0) ? 32'h8000_0000 : 32'h0) | 32'(i + 2);
      bus_read(1, 2'd0, d);  check($sformatf("drain_%0d", i), d, exp);
    end
    bus_read(1, 2'd0, d);  check("drain_new_last", d, 32'h0000_0019);
    bus_read(1, 2'd1, d);  check("drain_status", d, 32'h200);

    // Interrupt latency and release
    bus_write(1, 2'd2, 32'h7);
    level1 = 1'b1;
    tick(2);
    check("irq_before", 32'(irq1), 32'h0);
    tick(1);
    check("irq_raised", 32'(irq1), 32'h1);
    bus_read(1, 2'd0, d);  check("irq_entry", d, 32'h8000_0002);
    check("irq_dropped", 32'(irq1), 32'h0);
    bus_read(1, 2'd0, d);  check("empty_read", d, 32'h0);
    bus_read(1, 2'd1, d);  check("empty_status", d, 32'h200);

    // Clear with five queued entries and an edge in flight
    for (int i = 0; i < 5; i++) begin
      level1 = ~level1;
      tick(1);
    end
    tick(3);
    bus_read(1, 2'd1, d);  check("five_status", d, 32'h005);
    check("five_irq", 32'(irq1), 32'h1);
    level1 = ~level1;
    tick(2);
    bus_write(1, 2'd2, 32'h5);
    peek(1, 2'd3, d);      check("clr_ts", d, 32'h0);
    bus_read(1, 2'd1, d);  check("clr_status", d, 32'h200);
    bus_read(1, 2'd2, d);  check("clr_control", d, 32'h1);
    check("clr_irq", 32'(irq1), 32'h0);
    tick(3);
    bus_read(1, 2'd1, d);  check("clr_inflight_dropped", d, 32'h200);

    // Asynchronous reset pulse mid-stream
    bus_write(1, 2'd2, 32'h3);
    level1 = ~level1;
    tick(1);
    level1 = ~level1;
    tick(3);
    bus_read(1, 2'd1, d);  check("pre_reset_status", d, 32'h002);
    #2;
    reset = 1'b1;
    peek(1, 2'd1, d);  check("areset_status", d, 32'h200);
    peek(1, 2'd2, d);  check("areset_control", d, 32'h0);
    peek(1, 2'd3, d);  check("areset_ts", d, 32'h0);
    check("areset_irq", 32'(irq1), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(4);
    peek(1, 2'd0, d);  check("post_reset_data", d, 32'h0);
    peek(1, 2'd1, d);  check("post_reset_status", d, 32'h200);
    peek(1, 2'd3, d);  check("post_reset_ts", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
